// File: rtl/blackjack_pkg.sv
// Shared types and constants for the blackjack card shoe: FSM states, card
// value constants, per-deck counts and the LFSR feedback mask.
package blackjack_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRAW,
    SCAN,
    PRESENT,
    EMPTY
  } shoe_state_e;

  localparam logic [3:0] ACE = 4'd1;
  localparam logic [3:0] TEN = 4'd10;

  localparam int PER_VALUE      = 4;
  localparam int PER_TEN        = 16;
  localparam int CARDS_PER_DECK = 52;

  // x^16 + x^14 + x^13 + x^11 + 1 -> state bits 15, 13, 12, 10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] nonzero_seed(input logic [15:0] s);
    return (s == 16'h0000) ? 16'h0001 : s;
  endfunction

  // Low nibble of the LFSR to a card value; 0 marks a miss.
  function automatic logic [3:0] rank_to_value(input logic [3:0] r);
    if (r <= 4'd8)       return r + 4'd1;
    else if (r <= 4'd12) return TEN;
    else                 return 4'd0;
  endfunction

endpackage

// File: rtl/card_shoe_if.sv
// Request/present handshake between the card shoe and its consumer.
interface card_shoe_if;
  logic        req;
  logic        card_ready;
  logic        refill;
  logic        seed_load;
  logic [15:0] seed;
  logic [3:0]  card;
  logic        card_valid;
  logic        empty;
  logic [7:0]  remaining;

  modport master (
    output req, card_ready, refill, seed_load, seed,
    input  card, card_valid, empty, remaining
  );

  modport slave (
    input  req, card_ready, refill, seed_load, seed,
    output card, card_valid, empty, remaining
  );
endinterface

// File: rtl/shoe_lfsr.sv
// 16-bit Fibonacci LFSR with load/advance enables; a zero seed becomes 1 so
// the register can never lock up. Only the rank nibble leaves the block.
module shoe_lfsr
  import blackjack_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        advance,
  output logic [3:0]  rank
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load)         lfsr_d = nonzero_seed(load_val);
    else if (advance) lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) lfsr_q <= nonzero_seed(SEED);
    else          lfsr_q <= lfsr_d;
  end

  assign rank = lfsr_q[3:0];

endmodule

// File: rtl/card_shoe.sv
// Depletion-aware card dealer: per-value count store, LFSR draw with a
// bounded miss budget, and a lowest-value scan fallback.
module card_shoe
  import blackjack_pkg::*;
#(
  parameter int          DECKS = 1,
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input  logic     clock,
  input  logic     reset_n,
  card_shoe_if.slave shoe
);

  localparam logic [6:0] FULL_VAL = 7'(PER_VALUE * DECKS);
  localparam logic [6:0] FULL_TEN = 7'(PER_TEN * DECKS);
  localparam logic [7:0] FULL_REM = 8'(CARDS_PER_DECK * DECKS);

  shoe_state_e state_q, state_d;
  logic [3:0]  miss_q, miss_d;
  logic [3:0]  card_q, card_d;
  logic        card_valid_q, card_valid_d;
  logic [7:0]  remaining_q, remaining_d;
  logic [6:0]  count_q [1:10];
  logic [6:0]  count_d [1:10];

  logic [3:0]  rank, draw_val, scan_val, dec_val;
  logic        draw_hit, handshake, refill_now, lfsr_load, lfsr_adv;

  shoe_lfsr #(.SEED(SEED)) u_lfsr (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (lfsr_load),
    .load_val (shoe.seed),
    .advance  (lfsr_adv),
    .rank     (rank)
  );

  assign handshake  = card_valid_q && shoe.card_ready;
  assign refill_now = shoe.refill && (state_q == IDLE || state_q == EMPTY);
  assign lfsr_load  = (state_q == IDLE) && !shoe.refill && shoe.seed_load;
  assign lfsr_adv   = (state_q == DRAW) && !draw_hit;

  // A draw only hits when the mapped value still has cards left.
  always_comb begin
    draw_val = rank_to_value(rank);
    draw_hit = 1'b0;
    for (int v = 1; v <= 10; v++)
      if (draw_val == 4'(v) && count_q[v] != 7'd0) draw_hit = 1'b1;
  end

  always_comb begin
    scan_val = 4'd0;
    for (int v = int'(TEN); v >= int'(ACE); v--)
      if (count_q[v] != 7'd0) scan_val = 4'(v);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!shoe.refill && !shoe.seed_load && shoe.req) state_d = DRAW;
      DRAW:    if (draw_hit) state_d = PRESENT;
               else if (miss_q == 4'hF) state_d = SCAN;
      SCAN:    state_d = PRESENT;
      PRESENT: if (handshake) state_d = (remaining_q == 8'd0) ? EMPTY : IDLE;
      EMPTY:   if (shoe.refill) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    miss_d       = miss_q;
    card_d       = card_q;
    card_valid_d = card_valid_q;
    remaining_d  = remaining_q;
    count_d      = count_q;
    dec_val      = 4'd0;

    unique case (state_q)
      IDLE:    if (!shoe.refill && !shoe.seed_load && shoe.req) miss_d = 4'd0;
      DRAW:    if (draw_hit) dec_val = draw_val;
               else          miss_d  = miss_q + 4'd1;
      SCAN:    dec_val = scan_val;
      PRESENT: if (handshake) begin
                 card_d       = 4'd0;
                 card_valid_d = 1'b0;
               end
      default: ;
    endcase

    if (refill_now) begin
      for (int v = 1; v <= 10; v++) count_d[v] = (v == 10) ? FULL_TEN : FULL_VAL;
      remaining_d = FULL_REM;
    end

    // dec_val is only nonzero for a value whose count is nonzero.
    if (dec_val != 4'd0) begin
      for (int v = 1; v <= 10; v++)
        if (dec_val == 4'(v)) count_d[v] = count_q[v] - 7'd1;
      remaining_d  = remaining_q - 8'd1;
      card_d       = dec_val;
      card_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      miss_q       <= 4'd0;
      card_q       <= 4'd0;
      card_valid_q <= 1'b0;
      remaining_q  <= FULL_REM;
      for (int v = 1; v <= 10; v++) count_q[v] <= (v == 10) ? FULL_TEN : FULL_VAL;
    end else begin
      miss_q       <= miss_d;
      card_q       <= card_d;
      card_valid_q <= card_valid_d;
      remaining_q  <= remaining_d;
      count_q      <= count_d;
    end
  end

  assign shoe.card       = card_q;
  assign shoe.card_valid = card_valid_q;
  assign shoe.empty      = (state_q == EMPTY);
  assign shoe.remaining  = remaining_q;

endmodule

// File: tb/tb_card_shoe.sv
// Scoreboard bench for card_shoe: a shoe model predicts each dealt card,
// its remaining count and its request-to-valid latency.
module tb_card_shoe;

  localparam logic [15:0] TB_SEED = 16'h0005;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  card_shoe_if bus();

  card_shoe #(.DECKS(1), .SEED(TB_SEED)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .shoe    (bus.slave)
  );

  int total = 0;
  int bad   = 0;
  int exp_card_q[$];
  int exp_rem_q[$];
  int cnt[11];
  int mlfsr;
  int dut_hist[11];

  task automatic check(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, want);
    end
  endtask

  task automatic summary_and_finish();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  // ---------------- reference model ----------------
  function automatic int lfsr_next(input int x);
    int fb;
    fb = ((x >> 15) ^ (x >> 13) ^ (x >> 12) ^ (x >> 10)) & 1;
    return ((x << 1) | fb) & 'hFFFF;
  endfunction

  function automatic void model_full();
    for (int k = 1; k <= 9; k++) cnt[k] = 4;
    cnt[10] = 16;
  endfunction

  function automatic int model_rem();
    int s = 0;
    for (int k = 1; k <= 10; k++) s += cnt[k];
    return s;
  endfunction

  task automatic model_deal(output int v, output int lat);
    int r, val;
    v = 0;
    lat = 0;
    for (int m = 0; m < 16; m++) begin
      r = mlfsr & 15;
      val = (r <= 8) ? r + 1 : ((r <= 12) ? 10 : 0);
      if (val != 0 && cnt[val] > 0) begin
        cnt[val]--;
        v = val;
        lat = m + 2;
        return;
      end
      mlfsr = lfsr_next(mlfsr);
    end
    for (int k = 10; k >= 1; k--) if (cnt[k] > 0) v = k;
    cnt[v]--;
    lat = 18;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    if (reset_n && bus.card_valid && bus.card_ready) begin
      if (exp_card_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_card: got %0d, want no card", bus.card);
      end else begin
        check("card", int'(bus.card), exp_card_q.pop_front());
        check("remaining", int'(bus.remaining), exp_rem_q.pop_front());
        if (bus.card >= 4'd1 && bus.card <= 4'd10) dut_hist[int'(bus.card)]++;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic deal(input int hold, output int got);
    int v, lat_exp, lat, c0, r0;
    model_deal(v, lat_exp);
    exp_card_q.push_back(v);
    exp_rem_q.push_back(model_rem());
    bus.req = 1'b1;
    bus.card_ready = (hold == 0);
    step();
    bus.req = 1'b0;
    lat = 1;
    while (!bus.card_valid && lat < 30) begin
      step();
      lat++;
    end
    if (!bus.card_valid) begin
      total++;
      bad++;
      $display("FAIL deal_timeout: got no card_valid after %0d cycles, want it after %0d", lat, lat_exp);
      summary_and_finish();
    end
    check("latency", lat, lat_exp);
    got = int'(bus.card);
    if (hold > 0) begin
      c0 = int'(bus.card);
      r0 = int'(bus.remaining);
      for (int i = 0; i < hold; i++) begin
        bus.req    = 1'($urandom_range(0, 1));
        bus.refill = 1'($urandom_range(0, 1));
        step();
        check("held_card", int'(bus.card), c0);
        check("held_valid", int'(bus.card_valid), 1);
        check("held_remaining", int'(bus.remaining), r0);
      end
      bus.req = 1'b0;
      bus.refill = 1'b0;
      bus.card_ready = 1'b1;
    end
    step();
    bus.card_ready = 1'b0;
    check("card_cleared", int'(bus.card), 0);
    check("valid_cleared", int'(bus.card_valid), 0);
  endtask

  task automatic pulse_refill();
    bus.refill = 1'b1;
    step();
    bus.refill = 1'b0;
    model_full();
  endtask

  task automatic pulse_seed(input logic [15:0] s);
    bus.seed = s;
    bus.seed_load = 1'b1;
    step();
    bus.seed_load = 1'b0;
    mlfsr = (s == 16'h0000) ? 1 : int'(s);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int got;
    int quiet;
    bus.req = 1'b0;
    bus.card_ready = 1'b0;
    bus.refill = 1'b0;
    bus.seed_load = 1'b0;
    bus.seed = 16'h0000;
    reset_n = 1'b0;
    model_full();
    mlfsr = int'(TB_SEED);
    for (int k = 0; k <= 10; k++) dut_hist[k] = 0;

    #13;
    check("reset_valid", int'(bus.card_valid), 0);
    check("reset_card", int'(bus.card), 0);
    check("reset_empty", int'(bus.empty), 0);
    check("reset_remaining", int'(bus.remaining), 52);
    step();
    reset_n = 1'b1;

    // full drain: first deal, one backpressured deal, then the rest
    deal(0, got);
    check("first_card", got, 6);
    deal(5, got);
    for (int i = 0; i < 50; i++) deal(int'($urandom_range(0, 3)), got);

    check("drained_empty", int'(bus.empty), 1);
    check("drained_remaining", int'(bus.remaining), 0);
    for (int k = 1; k <= 9; k++) check("hist_value", dut_hist[k], 4);
    check("hist_ten", dut_hist[10], 16);

    quiet = 1;
    bus.req = 1'b1;
    bus.card_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.card_valid || !bus.empty) quiet = 0;
    end
    bus.req = 1'b0;
    bus.card_ready = 1'b0;
    check("empty_ignores_req", quiet, 1);

    // refill and zero seed from EMPTY
    pulse_refill();
    check("refill_remaining", int'(bus.remaining), 52);
    check("refill_empty", int'(bus.empty), 0);
    pulse_seed(16'h0000);
    deal(0, got);
    check("seed0_card", got, 2);
    for (int i = 0; i < 9; i++) deal(int'($urandom_range(0, 2)), got);

    // asynchronous reset while in DRAW
    bus.req = 1'b1;
    bus.card_ready = 1'b1;
    step();
    bus.req = 1'b0;
    reset_n = 1'b0;
    #1;
    check("midreset_valid", int'(bus.card_valid), 0);
    check("midreset_card", int'(bus.card), 0);
    check("midreset_remaining", int'(bus.remaining), 52);
    check("midreset_empty", int'(bus.empty), 0);
    bus.card_ready = 1'b0;
    model_full();
    mlfsr = int'(TB_SEED);
    step();
    reset_n = 1'b1;
    deal(0, got);
    check("post_reset_card", got, 6);

    // randomized deals with refills and seed loads in IDLE
    for (int i = 0; i < 30; i++) begin
      if (model_rem() == 0 || $urandom_range(0, 7) == 0) pulse_refill();
      if ($urandom_range(0, 5) == 0)
        pulse_seed(($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom_range(0, 65535)));
      deal(int'($urandom_range(0, 2)), got);
    end

    step();
    check("scoreboard_drained", exp_card_q.size(), 0);
    summary_and_finish();
  end

endmodule
